// File: rtl/shift_register_74595.sv
// 74LS595-style shift/storage register, modelled as a single-clock design.
// SRCLK and RCLK are treated as sampled strobes (synchronised, then edge-detected)
// rather than as clocks.

// Synchroniser for one input bit. STAGES=0 gives a plain wire for inputs that
// are already in the clk domain.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);
  generate
    if (STAGES == 0) begin : g_pass
      assign q = d;
    end else begin : g_sync
      logic [STAGES-1:0] ff;
      // Flop chain; ff[0] samples the pin and ff[STAGES-1] is the synced value.
      always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
          ff <= {STAGES{RST_VAL}};
        end else begin
          ff[0] <= d;
          for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
        end
      end
      assign q = ff[STAGES-1];
    end
  endgenerate
endmodule

module shift_register_74595 #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ser,
  input  logic             srclk,
  input  logic             rclk,
  input  logic             srclr_n,
  input  logic             oe_n,
  output logic [WIDTH-1:0] q,
  output logic             qh_s
);
  // Lane order: {srclr_n, rclk, srclk, ser}. The strobes and the clear reset
  // high, so a strobe held high across reset release is not seen as an edge.
  // All lanes share one depth, which keeps ser aligned with srclk.
  localparam int         NSYNC    = 4;
  localparam logic [3:0] SYNC_RST = 4'b1110;

  logic [NSYNC-1:0] raw, synced;
  logic             ser_s, srclk_s, rclk_s, srclr_s;
  logic             srclk_d, rclk_d;
  logic             sr_edge, rc_edge;
  logic [WIDTH-1:0] shift_reg, storage;

  assign raw = {srclr_n, rclk, srclk, ser};

  generate
    for (genvar i = 0; i < NSYNC; i++) begin : g_lane
      sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST[i])) u_sync (
        .clk  (clk),
        .clr_n(clr_n),
        .d    (raw[i]),
        .q    (synced[i])
      );
    end
  endgenerate

  assign {srclr_s, rclk_s, srclk_s, ser_s} = synced;

  // Edge history. It resets high so that the first edge needs a sampled low.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      srclk_d <= 1'b1;
      rclk_d  <= 1'b1;
    end else begin
      srclk_d <= srclk_s;
      rclk_d  <= rclk_s;
    end
  end

  assign sr_edge = srclk_s & ~srclk_d;
  assign rc_edge = rclk_s & ~rclk_d;

  // Shift register. The clear level wins over a shift edge in the same cycle.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)       shift_reg <= '0;
    else if (!srclr_s) shift_reg <= '0;
    else if (sr_edge)  shift_reg <= {shift_reg[WIDTH-2:0], ser_s};
  end

  // Storage latch. It takes the pre-shift and pre-clear contents, so tied
  // strobes leave it one stage behind.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)       storage <= '0;
    else if (rc_edge) storage <= shift_reg;
  end

  assign q    = oe_n ? '0 : storage;
  assign qh_s = shift_reg[WIDTH-1];
endmodule

// File: tb/tb_shift_register_74595.sv
// Bench for shift_register_74595. It checks a default instance and a
// SYNC_STAGES=0 instance, both driven from shared inputs. A reference model
// pushes expected q/qh_s to a scoreboard at drive time; the entries are popped
// once the synchronised strobe has taken effect.
module tb_shift_register_74595;
  logic       clk, clr_n, ser, srclk, rclk, srclr_n, oe_n;
  logic [7:0] q, q0;
  logic       qh_s, qh0;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       qh;
  } exp_t;
  exp_t sb[$];

  logic [7:0] exp_sr, exp_st;

  shift_register_74595 dut (
    .clk(clk), .clr_n(clr_n), .ser(ser), .srclk(srclk), .rclk(rclk),
    .srclr_n(srclr_n), .oe_n(oe_n), .q(q), .qh_s(qh_s)
  );

  shift_register_74595 #(.SYNC_STAGES(0)) dut0 (
    .clk(clk), .clr_n(clr_n), .ser(ser), .srclk(srclk), .rclk(rclk),
    .srclr_n(srclr_n), .oe_n(oe_n), .q(q0), .qh_s(qh0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag);
    exp_t e;
    e.tag = tag;
    e.q   = oe_n ? 8'h00 : exp_st;
    e.qh  = exp_sr[7];
    sb.push_back(e);
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_q"},    q,    e.q);
    chk({e.tag, "_qh"},   qh_s, e.qh);
    chk({e.tag, "_q0"},   q0,   e.q);
    chk({e.tag, "_qh0"},  qh0,  e.qh);
  endtask

  task automatic do_reset();
    srclk = 0; rclk = 0; srclr_n = 1; ser = 0;
    clr_n = 0;
    tick();
    clr_n = 1;
    repeat (3) tick();
    exp_sr = 0; exp_st = 0;
  endtask

  // One srclk pulse (optionally with rclk tied), then enough clks to settle.
  task automatic sr_pulse(input logic s, input logic tied, input string tag);
    ser = s; srclk = 1; rclk = tied;
    if (tied) exp_st = exp_sr;
    exp_sr = {exp_sr[6:0], s};
    sb_push(tag);
    tick();
    srclk = 0; rclk = 0;
    repeat (3) tick();
    sb_pop();
  endtask

  task automatic rc_pulse(input string tag);
    rclk = 1;
    exp_st = exp_sr;
    sb_push(tag);
    tick();
    rclk = 0;
    repeat (3) tick();
    sb_pop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;

    // Reset with both strobes held high across release: nothing may fire.
    clr_n = 0; ser = 1; srclk = 1; rclk = 1; srclr_n = 1; oe_n = 0;
    #12 clr_n = 1;
    repeat (6) tick();
    chk("rst_q", q, 8'h00);
    chk("rst_qh", qh_s, 1'b0);
    chk("rst_sr", dut.shift_reg, 8'h00);
    chk("rst_q0", q0, 8'h00);
    chk("rst_sr0", dut0.shift_reg, 8'h00);

    // Latency. Edge k is the first to sample srclk=1; srclk is held high 5 clks.
    srclk = 0; rclk = 0; ser = 0;
    repeat (4) tick();
    ser = 1; srclk = 1;
    tick();
    chk("lat2_k",  dut.shift_reg[0],  1'b0);
    chk("lat0_k",  dut0.shift_reg[0], 1'b1);
    tick();
    chk("lat2_k1", dut.shift_reg[0],  1'b0);
    tick();
    chk("lat2_k2", dut.shift_reg[0],  1'b1);
    repeat (2) tick();
    srclk = 0; ser = 0;
    repeat (4) tick();
    chk("hold_one", dut.shift_reg,  8'h01);
    chk("hold_one0", dut0.shift_reg, 8'h01);

    // Load 0xA5 MSB first, then store it.
    do_reset();
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) sr_pulse(pat[i], 1'b0, $sformatf("a5_s%0d", 7 - i));
    chk("a5_sr", dut.shift_reg, 8'hA5);
    rc_pulse("a5_store");

    // Tied strobes: storage trails the shift register by one pulse.
    do_reset();
    for (int i = 0; i < 3; i++) sr_pulse(1'b1, 1'b1, $sformatf("tied%0d", i));
    chk("tied_sr", dut.shift_reg, 8'h07);

    // Clear and output enable: storage=0x3C, shift_reg=0xFF.
    do_reset();
    pat = 8'h3C;
    for (int i = 7; i >= 0; i--) sr_pulse(pat[i], 1'b0, "ld3c");
    rc_pulse("st3c");
    for (int i = 0; i < 8; i++) sr_pulse(1'b1, 1'b0, "ldff");
    oe_n = 1; #1;
    sb_push("oe_off_full");
    sb_pop();
    oe_n = 0; #1;
    srclr_n = 0; rclk = 1;
    exp_st = exp_sr; exp_sr = 8'h00;
    sb_push("clr_store");
    tick();
    srclr_n = 1; rclk = 0;
    repeat (3) tick();
    sb_pop();
    chk("clr_sr", dut.shift_reg, 8'h00);
    oe_n = 1; #1;
    sb_push("oe_off");
    sb_pop();
    oe_n = 0; #1;
    sb_push("oe_on");
    sb_pop();

    // Async reset mid-pulse-train, between clk edges.
    for (int i = 0; i < 8; i++) sr_pulse(1'b1, 1'b0, "refill");
    ser = 1; srclk = 1; tick();
    srclk = 0; tick();
    srclk = 1; tick();
    #2 clr_n = 0;
    #1;
    chk("arst_q",   q,    8'h00);
    chk("arst_qh",  qh_s, 1'b0);
    chk("arst_q0",  q0,   8'h00);
    chk("arst_qh0", qh0,  1'b0);
    #1 clr_n = 1;
    exp_sr = 0; exp_st = 0;
    repeat (5) tick();
    chk("arst_hold",  dut.shift_reg,  8'h00);
    chk("arst_hold0", dut0.shift_reg, 8'h00);
    srclk = 0;
    repeat (2) tick();
    sr_pulse(1'b1, 1'b0, "resume");
    chk("resume_sr",  dut.shift_reg,  8'h01);
    chk("resume_sr0", dut0.shift_reg, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
